// File: rtl/uart_rx_ctrl.sv
// Controller for one uart_rx receiver: 16x tick divider, parity configuration and a
// show-ahead receive FIFO. Optional error counters are enabled by UART_RX_CTRL_ERR_CNT_EN.
module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cfg_enable,
    input  logic [DIV_WIDTH-1:0]             cfg_div,
    input  logic                             cfg_parity_en,
    output logic                             tick_16x,
    output logic                             parity_enable,
    input  logic [DATA_BITS-1:0]             rx_data,
    input  logic                             data_ready,
    input  logic                             parity_err,
    input  logic                             frame_err,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic [DATA_BITS-1:0]             rd_data,
    output logic                             rd_perr,
    output logic                             rd_ferr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
    output logic                             overflow,
    input  logic                             ovf_clr
`ifdef UART_RX_CTRL_ERR_CNT_EN
    ,
    output logic [7:0]                       perr_cnt,
    output logic [7:0]                       ferr_cnt,
    input  logic                             cnt_clr
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DATA_BITS + 2;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]        CNT_ONE_C = CW'(1'b1);
    localparam logic [AW-1:0]        PTR_ONE_C = AW'(1'b1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE_C = DIV_WIDTH'(1'b1);

    logic [DIV_WIDTH-1:0] div_cnt_r;
    logic [DIV_WIDTH-1:0] div_cnt_nxt_s;
    logic                 tick_r;
    logic                 tick_nxt_s;
    logic                 parity_r;

    logic [EW-1:0]        mem_r [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [CW-1:0]        count_r;
    logic [CW-1:0]        count_nxt_s;
    logic                 overflow_r;
    logic                 full_s;
    logic                 valid_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 drop_s;
    logic [EW-1:0]        head_s;

    // Divider next state: a count at or beyond cfg_div always ticks, so shrinking
    // the divisor mid-period restarts on the next cycle instead of wrapping around.
    always_comb begin
        div_cnt_nxt_s = {DIV_WIDTH{1'b0}};
        tick_nxt_s    = 1'b0;
        if (!cfg_enable) begin
            div_cnt_nxt_s = {DIV_WIDTH{1'b0}};
            tick_nxt_s    = 1'b0;
        end else if (div_cnt_r >= cfg_div) begin
            div_cnt_nxt_s = {DIV_WIDTH{1'b0}};
            tick_nxt_s    = 1'b1;
        end else begin
            div_cnt_nxt_s = div_cnt_r + DIV_ONE_C;
            tick_nxt_s    = 1'b0;
        end
    end

    // Divider counter and registered tick pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_r <= {DIV_WIDTH{1'b0}};
            tick_r    <= 1'b0;
        end else begin
            div_cnt_r <= div_cnt_nxt_s;
            tick_r    <= tick_nxt_s;
        end
    end

    // Parity setting follows the request only while idle so a frame never sees it change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            parity_r <= 1'b0;
        end else if (!cfg_enable) begin
            parity_r <= cfg_parity_en;
        end else begin
            parity_r <= parity_r;
        end
    end

    // FIFO handshake decode; a full FIFO still accepts a byte when the head leaves.
    always_comb begin
        valid_s = (count_r != {CW{1'b0}});
        full_s  = (count_r == DEPTH_C);
        pop_s   = valid_s && rd_ready;
        push_s  = data_ready && (!full_s || pop_s);
        drop_s  = data_ready && full_s && !pop_s;
    end

    // Occupancy next value.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage needs no reset: entries are only visible through count_r.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {frame_err, parity_err, rx_data};
        end
    end

    // Pointers, occupancy and sticky overflow flag (a new drop outranks a clear).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            count_r <= count_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    // Show-ahead read port, blanked while empty.
    always_comb begin
        head_s  = mem_r[rd_ptr_r];
        rd_data = {DATA_BITS{1'b0}};
        rd_perr = 1'b0;
        rd_ferr = 1'b0;
        if (valid_s) begin
            rd_data = head_s[DATA_BITS-1:0];
            rd_perr = head_s[DATA_BITS];
            rd_ferr = head_s[DATA_BITS+1];
        end else begin
            rd_data = {DATA_BITS{1'b0}};
            rd_perr = 1'b0;
            rd_ferr = 1'b0;
        end
    end

    assign tick_16x      = tick_r;
    assign parity_enable = parity_r;
    assign rd_valid      = valid_s;
    assign fifo_count    = count_r;
    assign overflow      = overflow_r;

`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0] perr_cnt_r;
    logic [7:0] ferr_cnt_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic inc);
        if (inc && (value != 8'hFF)) begin
            return value + 8'h01;
        end else begin
            return value;
        end
    endfunction

    // Error counters see every received byte, including ones the FIFO drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perr_cnt_r <= 8'h00;
            ferr_cnt_r <= 8'h00;
        end else if (cnt_clr) begin
            perr_cnt_r <= 8'h00;
            ferr_cnt_r <= 8'h00;
        end else begin
            perr_cnt_r <= sat_inc(perr_cnt_r, data_ready && parity_err);
            ferr_cnt_r <= sat_inc(ferr_cnt_r, data_ready && frame_err);
        end
    end

    assign perr_cnt = perr_cnt_r;
    assign ferr_cnt = ferr_cnt_r;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized FIFO traffic
// compared against a queue-based reference model.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_div = 16'd0;
    logic        cfg_parity_en = 1'b0;
    logic        tick_16x;
    logic        parity_enable;
    logic [7:0]  rx_data = 8'h00;
    logic        data_ready = 1'b0;
    logic        parity_err = 1'b0;
    logic        frame_err = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_perr;
    logic        rd_ferr;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        ovf_clr = 1'b0;
`ifdef UART_RX_CTRL_ERR_CNT_EN
    logic [7:0]  perr_cnt;
    logic [7:0]  ferr_cnt;
    logic        cnt_clr = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: queue of {ferr, perr, data}, sticky flag, error tallies.
    logic [9:0] q[$];
    bit         ovf_m = 1'b0;
    int         perr_m = 0;
    int         ferr_m = 0;

    uart_rx_ctrl #(.DATA_BITS(8), .DIV_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_div(cfg_div),
        .cfg_parity_en(cfg_parity_en), .tick_16x(tick_16x), .parity_enable(parity_enable),
        .rx_data(rx_data), .data_ready(data_ready), .parity_err(parity_err),
        .frame_err(frame_err), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
`ifdef UART_RX_CTRL_ERR_CNT_EN
        , .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .cnt_clr(cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    // Apply the rules of one clock edge to the model, then advance to just after the edge.
    task automatic clock_model();
        bit pop;
        bit full;
        pop  = (q.size() > 0) && rd_ready;
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (data_ready && (!full || pop)) q.push_back({frame_err, parity_err, rx_data});
        if (data_ready && full && !pop) ovf_m = 1'b1;
        else if (ovf_clr) ovf_m = 1'b0;
`ifdef UART_RX_CTRL_ERR_CNT_EN
        if (cnt_clr) begin
            perr_m = 0;
            ferr_m = 0;
        end else begin
            if (data_ready && parity_err && perr_m < 255) perr_m++;
            if (data_ready && frame_err && ferr_m < 255) ferr_m++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({tick_16x, parity_enable, rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overflow} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {tick_16x, parity_enable, rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overflow});
        end
        reset = 1'b1;
        clock_model();
    endtask

    task automatic test_divisor();
        cfg_div = 16'd5;
        cfg_enable = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            clock_model();
            checks++;
            if (tick_16x !== ((i % 6) == 0)) begin
                errors++;
                $display("FAIL tick_div5 cycle %0d: got %b expected %b", i, tick_16x, (i % 6) == 0);
            end
        end
        cfg_enable = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            clock_model();
            checks++;
            if (tick_16x !== 1'b0) begin
                errors++;
                $display("FAIL tick_disabled cycle %0d: got %b expected 0", i, tick_16x);
            end
        end
        // random divisors
        for (int r = 0; r < 4; r++) begin
            int d;
            d = $urandom_range(0, 7);
            cfg_enable = 1'b0;
            clock_model();
            cfg_div = 16'(d);
            cfg_enable = 1'b1;
            for (int i = 1; i <= 3 * (d + 1); i++) begin
                clock_model();
                checks++;
                if (tick_16x !== ((i % (d + 1)) == 0)) begin
                    errors++;
                    $display("FAIL tick_rand div %0d cycle %0d: got %b expected %b", d, i, tick_16x, (i % (d + 1)) == 0);
                end
            end
        end
        // shrinking the divisor below the running count
        cfg_enable = 1'b0;
        clock_model();
        cfg_div = 16'd10;
        cfg_enable = 1'b1;
        repeat (7) clock_model();
        cfg_div = 16'd3;
        for (int j = 0; j <= 8; j++) begin
            clock_model();
            checks++;
            if (tick_16x !== ((j % 4) == 0)) begin
                errors++;
                $display("FAIL tick_shrink step %0d: got %b expected %b", j, tick_16x, (j % 4) == 0);
            end
        end
        cfg_enable = 1'b0;
        clock_model();
    endtask

    task automatic test_parity();
        cfg_enable = 1'b0;
        cfg_parity_en = 1'b1;
        clock_model();
        checks++;
        if (parity_enable !== 1'b1) begin
            errors++;
            $display("FAIL parity_load: got %b expected 1", parity_enable);
        end
        cfg_enable = 1'b1;
        clock_model();
        for (int i = 0; i < 6; i++) begin
            cfg_parity_en = i[0];
            clock_model();
            checks++;
            if (parity_enable !== 1'b1) begin
                errors++;
                $display("FAIL parity_hold step %0d: got %b expected 1", i, parity_enable);
            end
        end
        cfg_parity_en = 1'b0;
        cfg_enable = 1'b0;
        clock_model();
        checks++;
        if (parity_enable !== 1'b0) begin
            errors++;
            $display("FAIL parity_reload: got %b expected 0", parity_enable);
        end
    endtask

    task automatic test_fifo_order();
        logic [7:0] bytes [3];
        logic       perrs [3];
        bytes = '{8'hA5, 8'h3C, 8'hFF};
        perrs = '{1'b1, 1'b0, 1'b0};
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_ready = 1'b1;
            rx_data = bytes[i];
            parity_err = perrs[i];
            frame_err = 1'b0;
            clock_model();
            if (i == 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
                    errors++;
                    $display("FAIL push_latency: valid %b data %h expected 1 a5", rd_valid, rd_data);
                end
            end
        end
        data_ready = 1'b0;
        parity_err = 1'b0;
        checks++;
        if (fifo_count !== 3'd3 || rd_valid !== 1'b1 || rd_data !== 8'hA5 || rd_perr !== 1'b1 || rd_ferr !== 1'b0) begin
            errors++;
            $display("FAIL fifo_head: count %0d valid %b data %h perr %b ferr %b expected 3 1 a5 1 0",
                     fifo_count, rd_valid, rd_data, rd_perr, rd_ferr);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== bytes[i] || rd_perr !== perrs[i]) begin
                errors++;
                $display("FAIL fifo_pop %0d: valid %b data %h perr %b expected 1 %h %b",
                         i, rd_valid, rd_data, rd_perr, bytes[i], perrs[i]);
            end
            clock_model();
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL fifo_empty: valid %b data %h count %0d expected 0 00 0", rd_valid, rd_data, fifo_count);
        end
        clock_model();
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_ready = 1'b1;
            rx_data = 8'(8'h10 + i);
            clock_model();
        end
        checks++;
        if (fifo_count !== 3'd4 || overflow !== 1'b1 || rd_data !== 8'h10) begin
            errors++;
            $display("FAIL overflow_drop: count %0d ovf %b head %h expected 4 1 10", fifo_count, overflow, rd_data);
        end
        rd_ready = 1'b1;
        rx_data = 8'h77;
        clock_model();
        checks++;
        if (fifo_count !== 3'd4 || rd_data !== 8'h11) begin
            errors++;
            $display("FAIL full_push_pop: count %0d head %h expected 4 11", fifo_count, rd_data);
        end
        rd_ready = 1'b0;
        ovf_clr = 1'b1;
        clock_model();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got %b expected 1", overflow);
        end
        data_ready = 1'b0;
        clock_model();
        ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got %b expected 0", overflow);
        end
        rd_ready = 1'b1;
        repeat (DEPTH + 1) clock_model();
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL ovf_drain: valid %b count %0d expected 0 0", rd_valid, fifo_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            data_ready = ($urandom_range(0, 1) == 1);
            rd_ready   = ($urandom_range(0, 2) == 0);
            ovf_clr    = ($urandom_range(0, 9) == 0);
            rx_data    = 8'($urandom);
            parity_err = ($urandom_range(0, 3) == 0);
            frame_err  = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_CTRL_ERR_CNT_EN
            cnt_clr    = ($urandom_range(0, 49) == 0);
`endif
            clock_model();
            checks++;
            if (rd_valid !== (q.size() > 0) || fifo_count !== 3'(q.size()) || overflow !== ovf_m ||
                {rd_ferr, rd_perr, rd_data} !== ((q.size() > 0) ? q[0] : 10'h000)) begin
                errors++;
                $display("FAIL random_fifo cycle %0d: valid %b count %0d ovf %b head %h expected %b %0d %b %h",
                         i, rd_valid, fifo_count, overflow, {rd_ferr, rd_perr, rd_data},
                         q.size() > 0, q.size(), ovf_m, (q.size() > 0) ? q[0] : 10'h000);
            end
`ifdef UART_RX_CTRL_ERR_CNT_EN
            checks++;
            if (perr_cnt !== 8'(perr_m) || ferr_cnt !== 8'(ferr_m)) begin
                errors++;
                $display("FAIL random_errcnt cycle %0d: perr %0d ferr %0d expected %0d %0d",
                         i, perr_cnt, ferr_cnt, perr_m, ferr_m);
            end
`endif
        end
        data_ready = 1'b0;
        ovf_clr = 1'b0;
        parity_err = 1'b0;
        frame_err = 1'b0;
`ifdef UART_RX_CTRL_ERR_CNT_EN
        cnt_clr = 1'b0;
`endif
        rd_ready = 1'b1;
        repeat (DEPTH + 1) clock_model();
        rd_ready = 1'b0;
    endtask

`ifdef UART_RX_CTRL_ERR_CNT_EN
    task automatic test_err_cnt();
        cnt_clr = 1'b1;
        clock_model();
        cnt_clr = 1'b0;
        rd_ready = 1'b1;
        data_ready = 1'b1;
        frame_err = 1'b1;
        parity_err = 1'b0;
        repeat (300) clock_model();
        checks++;
        if (ferr_cnt !== 8'd255 || perr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL err_saturate: ferr %0d perr %0d expected 255 0", ferr_cnt, perr_cnt);
        end
        cnt_clr = 1'b1;
        clock_model();
        checks++;
        if (ferr_cnt !== 8'd0 || perr_cnt !== 8'd0) begin
            errors++;
            $display("FAIL err_clear: ferr %0d perr %0d expected 0 0", ferr_cnt, perr_cnt);
        end
        cnt_clr = 1'b0;
        data_ready = 1'b0;
        frame_err = 1'b0;
        repeat (DEPTH + 1) clock_model();
        rd_ready = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_ready = 1'b1;
            rx_data = 8'(8'hC0 + i);
            clock_model();
        end
        data_ready = 1'b0;
        cfg_parity_en = 1'b1;
        clock_model();
        cfg_div = 16'd4;
        cfg_enable = 1'b1;
        repeat (3) clock_model();
        checks++;
        if (fifo_count !== 3'd2 || parity_enable !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: count %0d parity %b expected 2 1", fifo_count, parity_enable);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({tick_16x, parity_enable, rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overflow} !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %b expected all zero",
                     {tick_16x, parity_enable, rd_valid, rd_data, rd_perr, rd_ferr, fifo_count, overflow});
        end
        q.delete();
        ovf_m = 1'b0;
        perr_m = 0;
        ferr_m = 0;
        #1;
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            clock_model();
            checks++;
            if (tick_16x !== ((i % 5) == 0) || rd_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset cycle %0d: tick %b valid %b expected %b 0", i, tick_16x, rd_valid, (i % 5) == 0);
            end
        end
        cfg_enable = 1'b0;
        clock_model();
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_parity();
        test_fifo_order();
        test_overflow();
        test_random();
`ifdef UART_RX_CTRL_ERR_CNT_EN
        test_err_cnt();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
